// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing one main-memory interface between NUM_PORTS cache requesters.
// One transaction at a time: IDLE (arbitrate) -> BUSY (hold request) -> RESPOND (1 cycle) -> IDLE.
module main_memory_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int OFFSET_BITS   = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MSG_BITS      = 4,
  localparam int BUS_WIDTH    = DATA_WIDTH << OFFSET_BITS
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]      cache2arbiter_msg,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] cache2arbiter_address,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]     cache2arbiter_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]      arbiter2cache_msg,
  output logic [NUM_PORTS*ADDRESS_WIDTH-1:0] arbiter2cache_address,
  output logic [NUM_PORTS*BUS_WIDTH-1:0]     arbiter2cache_data,
  output logic [MSG_BITS-1:0]                arbiter2interface_msg,
  output logic [ADDRESS_WIDTH-1:0]           arbiter2interface_address,
  output logic [BUS_WIDTH-1:0]               arbiter2interface_data,
  input  logic [MSG_BITS-1:0]                interface2arbiter_msg,
  input  logic [ADDRESS_WIDTH-1:0]           interface2arbiter_address,
  input  logic [BUS_WIDTH-1:0]               interface2arbiter_data,
  output logic [NUM_PORTS-1:0]               grant
);

  localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] FLUSH    = MSG_BITS'(3);
  localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(10);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                             state_q;
  logic [PORT_BITS-1:0]               last_grant_q;
  logic [NUM_PORTS-1:0]               grant_q;
  logic [MSG_BITS-1:0]                if_msg_q;
  logic [ADDRESS_WIDTH-1:0]           if_addr_q;
  logic [BUS_WIDTH-1:0]               if_data_q;
  logic [NUM_PORTS*MSG_BITS-1:0]      c_msg_q;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] c_addr_q;
  logic [NUM_PORTS*BUS_WIDTH-1:0]     c_data_q;

  logic                 found_s;
  logic [PORT_BITS-1:0] win_s;
  logic [NUM_PORTS-1:0] valid_s;

  function automatic logic is_request(input logic [MSG_BITS-1:0] msg);
    case (msg)
      R_REQ, WB_REQ, FLUSH: is_request = 1'b1;
      default:              is_request = 1'b0;
    endcase
  endfunction

  // Per-port request decode.
  always_comb begin
    valid_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      valid_s[p] = is_request(cache2arbiter_msg[p*MSG_BITS +: MSG_BITS]);
    end
  end

  // Rotating-priority search starting just after the last owner.
  always_comb begin
    int idx;
    found_s = 1'b0;
    win_s   = '0;
    idx     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(last_grant_q) + 1 + i) % NUM_PORTS;
      if (!found_s && valid_s[idx]) begin
        found_s = 1'b1;
        win_s   = PORT_BITS'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Transaction FSM; every output is a register written here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_BITS'(NUM_PORTS - 1);
      grant_q      <= '0;
      if_msg_q     <= NO_REQ;
      if_addr_q    <= '0;
      if_data_q    <= '0;
      c_msg_q      <= '0;
      c_addr_q     <= '0;
      c_data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_s) begin
            if_msg_q     <= cache2arbiter_msg[int'(win_s)*MSG_BITS +: MSG_BITS];
            if_addr_q    <= cache2arbiter_address[int'(win_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            if_data_q    <= cache2arbiter_data[int'(win_s)*BUS_WIDTH +: BUS_WIDTH];
            grant_q      <= NUM_PORTS'(1) << win_s;
            last_grant_q <= win_s;
            state_q      <= BUSY;
          end else begin
            if_msg_q <= NO_REQ;
          end
        end
        BUSY: begin
          // Interface-side request is frozen until the reply; the interface drops back to IDLE next cycle.
          if (interface2arbiter_msg == MEM_RESP) begin
            if_msg_q  <= NO_REQ;
            if_addr_q <= '0;
            if_data_q <= '0;
            c_msg_q[int'(last_grant_q)*MSG_BITS +: MSG_BITS]            <= MEM_RESP;
            c_addr_q[int'(last_grant_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= interface2arbiter_address;
            c_data_q[int'(last_grant_q)*BUS_WIDTH +: BUS_WIDTH]         <= interface2arbiter_data;
            state_q   <= RESPOND;
          end else begin
            state_q <= BUSY;
          end
        end
        RESPOND: begin
          c_msg_q[int'(last_grant_q)*MSG_BITS +: MSG_BITS]            <= NO_REQ;
          c_addr_q[int'(last_grant_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= '0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          grant_q  <= '0;
          if_msg_q <= NO_REQ;
        end
      endcase
    end
  end

  assign arbiter2cache_msg         = c_msg_q;
  assign arbiter2cache_address     = c_addr_q;
  assign arbiter2cache_data        = c_data_q;
  assign arbiter2interface_msg     = if_msg_q;
  assign arbiter2interface_address = if_addr_q;
  assign arbiter2interface_data    = if_data_q;
  assign grant                     = grant_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed self-checking bench for main_memory_arbiter (2 ports, 128-bit lines).
module tb_main_memory_arbiter;

  localparam int NP = 2;
  localparam int MB = 4;
  localparam int AW = 32;
  localparam int BW = 128;

  logic              clock;
  logic              reset;
  logic [NP*MB-1:0]  c2a_msg;
  logic [NP*AW-1:0]  c2a_addr;
  logic [NP*BW-1:0]  c2a_data;
  logic [NP*MB-1:0]  a2c_msg;
  logic [NP*AW-1:0]  a2c_addr;
  logic [NP*BW-1:0]  a2c_data;
  logic [MB-1:0]     a2i_msg;
  logic [AW-1:0]     a2i_addr;
  logic [BW-1:0]     a2i_data;
  logic [MB-1:0]     i2a_msg;
  logic [AW-1:0]     i2a_addr;
  logic [BW-1:0]     i2a_data;
  logic [NP-1:0]     grant;

  int tests;
  int errors;

  localparam logic [BW-1:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [BW-1:0] WB_LN  = 128'h0000_0000_0000_0000_4444_3333_2222_1111;

  main_memory_arbiter #(
    .NUM_PORTS(NP), .OFFSET_BITS(2), .DATA_WIDTH(32), .ADDRESS_WIDTH(AW), .MSG_BITS(MB)
  ) dut (
    .clock(clock), .reset(reset),
    .cache2arbiter_msg(c2a_msg), .cache2arbiter_address(c2a_addr), .cache2arbiter_data(c2a_data),
    .arbiter2cache_msg(a2c_msg), .arbiter2cache_address(a2c_addr), .arbiter2cache_data(a2c_data),
    .arbiter2interface_msg(a2i_msg), .arbiter2interface_address(a2i_addr),
    .arbiter2interface_data(a2i_data),
    .interface2arbiter_msg(i2a_msg), .interface2arbiter_address(i2a_addr),
    .interface2arbiter_data(i2a_data),
    .grant(grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    c2a_msg = '0; c2a_addr = '0; c2a_data = '0;
    i2a_msg = '0; i2a_addr = '0; i2a_data = '0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (a2c_msg !== 8'h00 || a2i_msg !== 4'h0 || grant !== 2'b00 || a2i_addr !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d a2c_msg=%h a2i_msg=%h grant=%b exp 00/0/00", i, a2c_msg, a2i_msg, grant);
      end
    end
  endtask

  task automatic test_read();
    c2a_msg[3:0] = 4'd1; c2a_addr[31:0] = 32'h100;
    tick();
    tests++;
    if (a2i_msg !== 4'd1 || a2i_addr !== 32'h100 || grant !== 2'b01) begin
      errors++;
      $display("FAIL read_issue msg=%0d addr=%h grant=%b exp 1/100/01", a2i_msg, a2i_addr, grant);
    end
    tick();
    tick();
    tests++;
    if (a2i_msg !== 4'd1 || a2c_msg !== 8'h00) begin
      errors++;
      $display("FAIL read_hold a2i_msg=%0d a2c_msg=%h exp 1/00", a2i_msg, a2c_msg);
    end
    i2a_msg = 4'd10; i2a_addr = 32'h100; i2a_data = LINE_A;
    tick();
    tests++;
    if (a2c_msg[3:0] !== 4'd10 || a2c_addr[31:0] !== 32'h100 || a2c_data[127:0] !== LINE_A ||
        a2c_msg[7:4] !== 4'd0 || a2i_msg !== 4'd0 || a2i_addr !== 32'h0) begin
      errors++;
      $display("FAIL read_resp p0msg=%0d p0addr=%h p0data=%h p1msg=%0d a2i=%0d exp 10/100/%h/0/0",
               a2c_msg[3:0], a2c_addr[31:0], a2c_data[127:0], a2c_msg[7:4], a2i_msg, LINE_A);
    end
    i2a_msg = 4'd0; c2a_msg[3:0] = 4'd0;
    tick();
    tests++;
    if (a2c_msg !== 8'h00 || a2c_addr[31:0] !== 32'h0 || grant !== 2'b00 || a2c_data[127:0] !== LINE_A) begin
      errors++;
      $display("FAIL read_respond_end a2c_msg=%h addr=%h grant=%b data=%h exp 00/0/00/line",
               a2c_msg, a2c_addr[31:0], grant, a2c_data[127:0]);
    end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] exp_g;
    logic [NP-1:0] seen;
    int waited;
    do_reset();
    c2a_msg = {4'd1, 4'd1}; c2a_addr = {32'h200, 32'h300};
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      waited = 0;
      seen = '0;
      while (seen == '0 && waited < 10) begin
        tick();
        seen = grant;
        waited++;
      end
      tests++;
      if (seen !== exp_g) begin
        errors++;
        $display("FAIL rr_grant txn=%0d grant=%b exp %b", t, seen, exp_g);
      end
      i2a_msg = 4'd10; i2a_addr = 32'h5; i2a_data = '0;
      tick();
      i2a_msg = 4'd0;
      tests++;
      if (exp_g == 2'b01 ? (a2c_msg !== 8'h0A) : (a2c_msg !== 8'hA0)) begin
        errors++;
        $display("FAIL rr_resp txn=%0d a2c_msg=%h exp %h", t, a2c_msg, (exp_g == 2'b01) ? 8'h0A : 8'hA0);
      end
      tick();
    end
    c2a_msg = '0;
    tick();
  endtask

  task automatic test_wb_hold();
    c2a_msg = {4'd2, 4'd0}; c2a_addr = {32'h40, 32'h0}; c2a_data = {WB_LN, 128'h0};
    tick();
    tests++;
    if (a2i_msg !== 4'd2 || a2i_addr !== 32'h40 || a2i_data !== WB_LN || grant !== 2'b10) begin
      errors++;
      $display("FAIL wb_issue msg=%0d addr=%h data=%h grant=%b exp 2/40/%h/10", a2i_msg, a2i_addr, a2i_data, grant, WB_LN);
    end
    c2a_msg[7:4] = 4'd1; c2a_addr[63:32] = 32'h80; c2a_data[255:128] = {4{32'hFFFF_FFFF}};
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (a2i_msg !== 4'd2 || a2i_addr !== 32'h40 || a2i_data !== WB_LN) begin
        errors++;
        $display("FAIL wb_hold cyc=%0d msg=%0d addr=%h data=%h exp 2/40/%h", i, a2i_msg, a2i_addr, a2i_data, WB_LN);
      end
    end
    i2a_msg = 4'd10; i2a_addr = 32'h40; i2a_data = '0;
    tick();
    i2a_msg = 4'd0; c2a_msg = '0;
    tests++;
    if (a2i_data !== 128'h0 || a2i_msg !== 4'd0 || a2c_msg !== 8'hA0) begin
      errors++;
      $display("FAIL wb_resp a2i_data=%h a2i_msg=%0d a2c_msg=%h exp 0/0/A0", a2i_data, a2i_msg, a2c_msg);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_busy();
    c2a_msg = {4'd1, 4'd0}; c2a_addr = {32'h60, 32'h0}; c2a_data = '0;
    tick();
    tests++;
    if (grant !== 2'b10 || a2i_msg !== 4'd1) begin
      errors++;
      $display("FAIL rb_grant grant=%b a2i_msg=%0d exp 10/1", grant, a2i_msg);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (grant !== 2'b00 || a2i_msg !== 4'd0 || a2i_addr !== 32'h0 || a2i_data !== 128'h0 || a2c_msg !== 8'h00) begin
      errors++;
      $display("FAIL rb_cleared grant=%b a2i_msg=%0d addr=%h a2c_msg=%h exp 00/0/0/00", grant, a2i_msg, a2i_addr, a2c_msg);
    end
    c2a_msg = {4'd1, 4'd1};
    tick();
    tests++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL rb_next_port0 grant=%b exp 01", grant);
    end
    i2a_msg = 4'd10;
    tick();
    i2a_msg = 4'd0; c2a_msg = '0;
    tick();
    tick();
  endtask

  task automatic test_spurious();
    c2a_msg = {4'd11, 4'd10};
    i2a_msg = 4'd10; i2a_addr = 32'h999; i2a_data = LINE_A;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (grant !== 2'b00 || a2c_msg !== 8'h00 || a2i_msg !== 4'd0) begin
        errors++;
        $display("FAIL spurious cyc=%0d grant=%b a2c_msg=%h a2i_msg=%0d exp 00/00/0", i, grant, a2c_msg, a2i_msg);
      end
    end
    i2a_msg = 4'd0; c2a_msg = '0;
  endtask

  initial begin
    tests = 0;
    errors = 0;
    reset = 1'b1;
    test_reset();
    test_read();
    test_round_robin();
    test_wb_hold();
    test_reset_busy();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
